// File: rtl/mandel_pkg.sv
// rtl/mandel_pkg.sv - shared types, constants and helpers for the Mandelbrot iteration engine
package mandel_pkg;

  localparam int WIDTH_DEF  = 25;
  localparam int FBITS_DEF  = 21;
  localparam int ITER_W_DEF = 8;

  localparam logic [WIDTH_DEF:0]   ESCAPE_MAG = (WIDTH_DEF+1)'(4 << FBITS_DEF);
  localparam logic [WIDTH_DEF-1:0] C_LIMIT    = WIDTH_DEF'(2 << FBITS_DEF);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ISSUE_XX,
    S_WAIT_XX,
    S_ISSUE_YY,
    S_WAIT_YY,
    S_ISSUE_XY,
    S_WAIT_XY,
    S_CHECK,
    S_FINISH
  } mandel_state_e;

  // Symmetric magnitude test; operands are sign-extended so the most negative code is safe.
  function automatic logic abs_gt(input logic signed [31:0] v, input logic signed [31:0] lim);
    return (v > lim) || (v < -lim);
  endfunction

endpackage

// File: rtl/mandel_iter.sv
// rtl/mandel_iter.sv - z = z^2 + c escape-time engine driving an external shared multiplier
// Optional cycle counter output enabled by MANDEL_ITER_STATS_EN.
module mandel_iter
  import mandel_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int FBITS  = FBITS_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  cx,
  input  logic [WIDTH-1:0]  cy,
  input  logic [ITER_W-1:0] max_iter,
  output logic              busy,
  output logic              done,
  output logic              escaped,
  output logic [ITER_W-1:0] iter,
`ifdef MANDEL_ITER_STATS_EN
  output logic [31:0]       cycles,
`endif
  output logic              mul_start,
  output logic [WIDTH-1:0]  mul_a,
  output logic [WIDTH-1:0]  mul_b,
  input  logic              mul_done,
  input  logic [WIDTH-1:0]  mul_val,
  input  logic              mul_ovf
);

  localparam logic signed [WIDTH:0] ESC_MAG = signed'((WIDTH+1)'(4 << FBITS));
  localparam logic signed [31:0]    C_LIM   = 32'(2 << FBITS);

  mandel_state_e     state_q;
  logic [WIDTH-1:0]  cx_q, cy_q, x_q, y_q, x2_q, y2_q, xy_q;
  logic [ITER_W-1:0] max_q, count_q, iter_q;
  logic              ovf_q, esc_q;
  logic              busy_q, done_q, escaped_q, mul_start_q;
  logic [WIDTH-1:0]  mul_a_q, mul_b_q;
`ifdef MANDEL_ITER_STATS_EN
  logic [31:0]       cyc_q, cycles_q;
`endif

  logic signed [WIDTH:0] mag_d;
  logic [WIDTH-1:0]      x_d, y_d;
  logic [ITER_W-1:0]     count_d;
  logic                  escape_d, c_out_d;

  // Squares are non-negative, so only the one extra bit is needed for the sum.
  assign mag_d    = $signed({x2_q[WIDTH-1], x2_q}) + $signed({y2_q[WIDTH-1], y2_q});
  assign escape_d = ovf_q || (mag_d > ESC_MAG);
  assign x_d      = x2_q - y2_q + cx_q;
  assign y_d      = {xy_q[WIDTH-2:0], 1'b0} + cy_q;
  assign count_d  = count_q + ITER_W'(1);
  assign c_out_d  = abs_gt(32'($signed(cx)), C_LIM) || abs_gt(32'($signed(cy)), C_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x2_q        <= '0;
      y2_q        <= '0;
      xy_q        <= '0;
      max_q       <= '0;
      count_q     <= '0;
      iter_q      <= '0;
      ovf_q       <= 1'b0;
      esc_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      escaped_q   <= 1'b0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`ifdef MANDEL_ITER_STATS_EN
      cyc_q       <= '0;
      cycles_q    <= '0;
`endif
    end else begin
      done_q      <= 1'b0;
      mul_start_q <= 1'b0;
`ifdef MANDEL_ITER_STATS_EN
      if (state_q != S_IDLE) cyc_q <= cyc_q + 32'd1;
`endif
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cx_q    <= cx;
            cy_q    <= cy;
            max_q   <= max_iter;
            x_q     <= '0;
            y_q     <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
`ifdef MANDEL_ITER_STATS_EN
            cyc_q   <= 32'd1;
`endif
            if (c_out_d) begin
              esc_q   <= 1'b1;
              state_q <= S_FINISH;
            end else if (max_iter == '0) begin
              esc_q   <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              esc_q       <= 1'b0;
              mul_start_q <= 1'b1;
              mul_a_q     <= '0;
              mul_b_q     <= '0;
              state_q     <= S_ISSUE_XX;
            end
          end
        end
        S_ISSUE_XX: state_q <= S_WAIT_XX;
        S_ISSUE_YY: state_q <= S_WAIT_YY;
        S_ISSUE_XY: state_q <= S_WAIT_XY;
        S_WAIT_XX: begin
          if (mul_done) begin
            x2_q        <= mul_val;
            ovf_q       <= ovf_q | mul_ovf;
            mul_start_q <= 1'b1;
            mul_a_q     <= y_q;
            mul_b_q     <= y_q;
            state_q     <= S_ISSUE_YY;
          end
        end
        S_WAIT_YY: begin
          if (mul_done) begin
            y2_q        <= mul_val;
            ovf_q       <= ovf_q | mul_ovf;
            mul_start_q <= 1'b1;
            mul_a_q     <= x_q;
            mul_b_q     <= y_q;
            state_q     <= S_ISSUE_XY;
          end
        end
        S_WAIT_XY: begin
          if (mul_done) begin
            xy_q    <= mul_val;
            ovf_q   <= ovf_q | mul_ovf;
            state_q <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (escape_d) begin
            esc_q   <= 1'b1;
            state_q <= S_FINISH;
          end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
            ovf_q   <= 1'b0;
            if (count_d == max_q) begin
              esc_q   <= 1'b0;
              state_q <= S_FINISH;
            end else begin
              mul_start_q <= 1'b1;
              mul_a_q     <= x_d;
              mul_b_q     <= x_d;
              state_q     <= S_ISSUE_XX;
            end
          end
        end
        S_FINISH: begin
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          iter_q    <= count_q;
          escaped_q <= esc_q;
`ifdef MANDEL_ITER_STATS_EN
          cycles_q  <= cyc_q + 32'd1;
`endif
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign escaped   = escaped_q;
  assign iter      = iter_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
`ifdef MANDEL_ITER_STATS_EN
  assign cycles    = cycles_q;
`endif

endmodule

// File: tb/tb_mandel_iter.sv
// tb/tb_mandel_iter.sv - directed self-checking bench for mandel_iter with a behavioural multiplier
module tb_mandel_iter;

  localparam int W  = 25;
  localparam int FB = 21;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  cx = '0;
  logic [W-1:0]  cy = '0;
  logic [IW-1:0] max_iter = '0;
  logic          busy, done, escaped, mul_start;
  logic [IW-1:0] iter;
  logic [W-1:0]  mul_a, mul_b;
  logic          mul_done = 1'b0;
  logic [W-1:0]  mul_val = '0;
  logic          mul_ovf = 1'b0;
`ifdef MANDEL_ITER_STATS_EN
  logic [31:0]   cycles;
`endif

  int checks = 0;
  int failures = 0;

  int           lat = 2;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           m_cnt = 0;
  logic         m_pend = 1'b0;
  int           n_starts = 0;

  mandel_iter #(.WIDTH(W), .FBITS(FB), .ITER_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .cx(cx), .cy(cy), .max_iter(max_iter),
    .busy(busy), .done(done), .escaped(escaped), .iter(iter),
`ifdef MANDEL_ITER_STATS_EN
    .cycles(cycles),
`endif
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_val(mul_val), .mul_ovf(mul_ovf)
  );

  always #5 clk = ~clk;

  // Signed fixed-point product rounded half-up, with overflow when it leaves W bits.
  function automatic logic [W:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] p, r;
    logic ov;
    p  = 64'($signed(a)) * 64'($signed(b));
    r  = (p + (64'sd1 <<< (FB-1))) >>> FB;
    ov = (r > 64'sd16777215) || (r < -64'sd16777216);
    return {ov, r[W-1:0]};
  endfunction

  always @(posedge clk) begin
    mul_done <= 1'b0;
    if (mul_start) begin
      n_starts <= n_starts + 1;
      m_a      <= mul_a;
      m_b      <= mul_b;
      m_cnt    <= lat;
      m_pend   <= 1'b1;
    end else if (m_pend) begin
      if (m_cnt <= 1) begin
        mul_done           <= 1'b1;
        {mul_ovf, mul_val} <= mul_model(m_a, m_b);
        m_pend             <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int latency);
    bit got;
    got = 1'b0;
    latency = 0;
    for (int k = 1; k <= budget && !got; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        latency = k;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  task automatic run_pixel(input string tag, input logic [W-1:0] c_x, input logic [W-1:0] c_y,
                           input logic [IW-1:0] mi, input int budget,
                           output int latency, output int starts);
    int base;
    @(negedge clk);
    cx = c_x;
    cy = c_y;
    max_iter = mi;
    start = 1'b1;
    base = n_starts;
    wait_done(tag, budget, latency);
    starts = n_starts - base;
  endtask

  initial begin
    int lat_o, st, base;
    bit reached;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_escaped", 32'(escaped), 0);
    check("rst_iter", 32'(iter), 0);
    check("rst_mul_start", 32'(mul_start), 0);
    check("rst_mul_a", 32'(mul_a), 0);
    rst = 1'b0;

    // c = 0 runs to the limit; a second start mid-run must be ignored
    @(negedge clk);
    cx = '0; cy = '0; max_iter = 8'd16; start = 1'b1; base = n_starts;
    @(negedge clk);
    start = 1'b0;
    check("zero_busy", 32'(busy), 1);
    repeat (5) @(negedge clk);
    max_iter = 8'd3; start = 1'b1;
    wait_done("zero", 2000, lat_o);
    st = n_starts - base;
    check("zero_iter", 32'(iter), 16);
    check("zero_escaped", 32'(escaped), 0);
    check("zero_mul_starts", 32'(st), 48);
    check("zero_busy_at_done", 32'(busy), 0);

    lat = 1;
    run_pixel("c2", 25'h0400000, 25'h0, 8'd16, 2000, lat_o, st);
    check("c2_iter", 32'(iter), 2);
    check("c2_escaped", 32'(escaped), 1);

    lat = 2;
    run_pixel("cm2", 25'h1C00000, 25'h0, 8'd200, 8000, lat_o, st);
    check("cm2_iter", 32'(iter), 200);
    check("cm2_escaped", 32'(escaped), 0);

    lat = 4;
    run_pixel("c11", 25'h0200000, 25'h0200000, 8'd50, 2000, lat_o, st);
    check("c11_iter", 32'(iter), 2);
    check("c11_escaped", 32'(escaped), 1);

    // Reset while the y*y product is outstanding
    lat = 3;
    @(negedge clk);
    cx = 25'h0100000; cy = 25'h0100000; max_iter = 8'd50; start = 1'b1; base = n_starts;
    reached = 1'b0;
    for (int k = 0; k < 60 && !reached; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (n_starts - base >= 2) reached = 1'b1;
    end
    check("mid_reached_wait_yy", 32'(reached), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_escaped", 32'(escaped), 0);
    check("mid_rst_iter", 32'(iter), 0);
    check("mid_rst_mul_a", 32'(mul_a), 0);
    check("mid_rst_mul_b", 32'(mul_b), 0);
    @(negedge clk);
    rst = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      @(negedge clk);
      check("stale_no_done", 32'(done), 0);
      if (!m_pend) reached = 1'b1;
    end
    check("stale_delivered", 32'(reached), 1);
    repeat (2) @(negedge clk);
    check("stale_busy", 32'(busy), 0);
    check("stale_mul_start", 32'(mul_start), 0);
    run_pixel("fresh", 25'h0, 25'h0, 8'd4, 500, lat_o, st);
    check("fresh_iter", 32'(iter), 4);
    check("fresh_escaped", 32'(escaped), 0);
    check("fresh_mul_starts", 32'(st), 12);

    run_pixel("mi0", 25'h0100000, 25'h0, 8'd0, 20, lat_o, st);
    check("mi0_latency", 32'(lat_o), 2);
    check("mi0_iter", 32'(iter), 0);
    check("mi0_escaped", 32'(escaped), 0);
    check("mi0_mul_starts", 32'(st), 0);
`ifdef MANDEL_ITER_STATS_EN
    check("mi0_cycles", cycles, 2);
`endif

    run_pixel("c25", 25'h0500000, 25'h0, 8'd20, 20, lat_o, st);
    check("c25_iter", 32'(iter), 0);
    check("c25_escaped", 32'(escaped), 1);
    check("c25_mul_starts", 32'(st), 0);
    check("c25_latency", 32'(lat_o), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mandel_iter.md
Name: mandel_iter

Overview:
- Iteration engine for the Mandelbrot renderer. Computes z(n+1) = z(n)^2 + c from z(0) = 0 for one pixel coordinate c, and reports the escape iteration.
- Sits directly upstream of the shared signed fixed-point multiplier (start/done/ovf/val handshake). It sequences three products per iteration and consumes the rounded results and overflow flags.

Parameters:
- WIDTH, 25, fixed-point width of all coordinates and products (integer + fractional bits).
- FBITS, 21, fractional bits within WIDTH; 4.0 = 4 << FBITS.
- ITER_W, 8, width of iteration counter and max_iter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin a pixel; accepted only in IDLE
- cx  in  WIDTH  signed real part of c
- cy  in  WIDTH  signed imaginary part of c
- max_iter  in  ITER_W  iteration limit
- busy  out  1  pixel in progress
- done  out  1  result ready, one-cycle pulse
- escaped  out  1  1 = point escaped, 0 = limit reached
- iter  out  ITER_W  completed iterations at escape or at limit
- mul_start  out  1  one-cycle multiplier request
- mul_a  out  WIDTH  signed factor a, held from mul_start until mul_done
- mul_b  out  WIDTH  signed factor b, held from mul_start until mul_done
- mul_done  in  1  multiplier result strobe
- mul_val  in  WIDTH  signed rounded product, sampled on mul_done
- mul_ovf  in  1  product overflow, sampled on mul_done

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, escaped, mul_start = 0; iter, mul_a, mul_b = 0; internal x, y, x2, y2, xy, count cleared.
- States: IDLE, ISSUE_XX, WAIT_XX, ISSUE_YY, WAIT_YY, ISSUE_XY, WAIT_XY, CHECK, FINISH.
- IDLE with start=1:
  - Latch cx, cy, max_iter; x = y = 0; count = 0; busy <= 1.
  - If |cx| > 2.0 or |cy| > 2.0: go to FINISH with escaped = 1, count = 0.
  - Else if max_iter == 0: go to FINISH with escaped = 0.
  - Else go to ISSUE_XX.
- ISSUE_* (one cycle): mul_start = 1; operands are (x,x), (y,y) or (x,y) respectively. Next state is the matching WAIT_*.
- WAIT_*: hold operands and keep mul_start = 0 until mul_done. On mul_done, store mul_val into x2, y2 or xy, OR mul_ovf into a sticky ovf flag, and advance. Any multiplier latency of 1 cycle or more is supported.
- CHECK (one cycle):
  - mag = x2 + y2, computed at WIDTH+1 bits.
  - Escape if ovf sticky = 1 or mag > 4.0 (strictly greater). Escape goes to FINISH with escaped = 1 and iter = count.
  - Otherwise: x <= x2 - y2 + cx; y <= (xy << 1) + cy; count++; clear ovf sticky.
  - If the new count == max_iter: FINISH with escaped = 0; else ISSUE_XX.
  - These sums cannot overflow WIDTH given |c| <= 2 and mag <= 4.
- FINISH (one cycle): done = 1, busy = 0, iter/escaped updated; return to IDLE. iter/escaped hold until the next accepted start.
- start while busy: ignored.
- mul_done while in IDLE, ISSUE_* or FINISH: ignored.
- Reset mid-pixel: immediate return to IDLE, no done pulse. The caller must also reset the multiplier.

Optional Feature:
- Macro MANDEL_ITER_STATS_EN.
- Defined: extra output cycles [31:0], reset 0. It counts clocks from the accepting start cycle through FINISH inclusive, is updated at FINISH, and holds until the next accepted start.
- Undefined: port and counter absent; no other behaviour change.

Decomposition:
- Package mandel_pkg holds:
  - the state enum type;
  - localparams ESCAPE_MAG = 4 << FBITS and C_LIMIT = 2 << FBITS, as functions of WIDTH/FBITS;
  - a function abs_gt for the signed range check.
- No sub-module. The multiplier stays external so it can be shared or swapped; the bench uses a behavioural multiplier model with configurable latency.

Test Plan:
- c=(0,0), max_iter=16 -> done with iter=16, escaped=0; exactly 48 mul_start pulses.
- c=(2.0,0) = (0x400000,0), max_iter=16 -> z1=(2,0) passes (mag=4.0, not >4); z2=(6,0); x*x overflows -> iter=2, escaped=1.
- c=(-2.0,0), max_iter=200 -> orbit fixed at x=2.0, never escapes -> iter=200, escaped=0.
- c=(1.0,1.0), max_iter=50 -> z1=(1,1), z2=(1,3); y*y=9 sets mul_ovf -> iter=2, escaped=1.
- Edge inputs:
  - max_iter=0 -> done two cycles after start, iter=0, escaped=0, no mul_start.
  - cx=0x500000 (2.5) -> iter=0, escaped=1, no mul_start.
- Reset mid-pixel during WAIT_YY -> busy=0 and outputs at reset values immediately. A later stale mul_done is ignored, and a fresh start with c=(0,0), max_iter=4 completes correctly. With MANDEL_ITER_STATS_EN, max_iter=0 -> cycles=2.
